// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and helpers for the round-robin arbiter slice:
//            arbiter state encoding, integer log-base function and the
//            thermometer-to-one-hot conversion.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Widest vector the one-hot helper accepts; callers size-cast in and out.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Smallest n such that base**n >= value (value >= 1, base >= 2).
  function automatic int clogbase(input int value, input int base);
    int n;
    int p;
    n = 0;
    p = 1;
    while (p < value) begin
      p = p * base;
      n = n + 1;
    end
    return n;
  endfunction

  // An LSB thermometer has exactly one 0->1 edge; isolate it.
  function automatic logic [MAX_W-1:0] onehot_from_thr(input logic [MAX_W-1:0] thr);
    return thr & ~(thr << 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pry2thr.sv
`default_nettype none
// ============================================================================
// Module   : pry2thr
// Brief    : Priority-to-thermometer. With DIRECTION="LSB", thr[i]=1 for
//            every i at or above the lowest set bit of pry; "MSB" mirrors
//            this. The input is zero-padded to SPLIT**levels so any WIDTH
//            works. IMPLEMENTATION 0 = ripple scan, otherwise log-depth scan.
// Revision : 1.0 - initial release
// ============================================================================
module pry2thr
  import arb_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  parameter     DIRECTION      = "LSB"
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] thr,
  output logic             vld
);

  localparam int C_LEVELS = clogbase(WIDTH, SPLIT);
  localparam int C_PW     = SPLIT ** C_LEVELS;

  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_out;
  logic [C_PW-1:0]  w_pad;
  logic [C_PW-1:0]  w_scan;

  // Orientation: the scan always runs LSB-first, MSB mode mirrors around it.
  generate
    if (DIRECTION == "MSB") begin : g_msb
      for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_in[i] = pry[WIDTH-1-i];
        assign thr[i]  = w_out[WIDTH-1-i];
      end
    end else begin : g_lsb
      assign w_in = pry;
      assign thr  = w_out;
    end
  endgenerate

  assign w_pad = C_PW'(w_in);

  generate
    if (IMPLEMENTATION == 0) begin : g_ripple
      // Linear prefix-OR from bit 0 upward.
      always_comb begin
        w_scan    = '0;
        w_scan[0] = w_pad[0];
        for (int i = 1; i < C_PW; i++) begin
          w_scan[i] = w_scan[i-1] | w_pad[i];
        end
      end
    end else begin : g_tree
      // Log-depth prefix-OR by doubling shift distance.
      always_comb begin
        w_scan = w_pad;
        for (int s = 1; s < C_PW; s = s * 2) begin
          w_scan = w_scan | (w_scan << s);
        end
      end
    end
  endgenerate

  // Pad bits are zero, so every bit from WIDTH-1 upward equals "any set".
  assign w_out = w_scan[WIDTH-1:0];
  assign vld   = |w_scan[C_PW-1:WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/rrb_arb.sv
`default_nettype none
// ============================================================================
// Module   : rrb_arb
// Brief    : Round-robin arbiter with a registered one-hot grant held until
//            the consumer accepts a beat flagged last. Masked and unmasked
//            pry2thr searches pick the next winner above the last one.
// Revision : 1.0 - initial release
// ============================================================================
module rrb_arb
  import arb_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0]         gnt,
  output logic                     gnt_vld,
  output logic [$clog2(WIDTH)-1:0] gnt_idx,
  input  logic                     ack,
  input  logic                     lst
);

  localparam int C_IW = $clog2(WIDTH);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_gnt;
  logic [WIDTH-1:0] w_gnt_nxt;
  logic [WIDTH-1:0] r_msk;
  logic [WIDTH-1:0] w_msk_nxt;
  logic [C_IW-1:0]  r_idx;
  logic [C_IW-1:0]  w_idx_nxt;
  logic [C_IW-1:0]  w_idx_sel;
  logic [WIDTH-1:0] w_msk_above;
  logic [WIDTH-1:0] w_req_eff;
  logic [WIDTH-1:0] w_msk_eff;
  logic [WIDTH-1:0] w_req_m;
  logic [WIDTH-1:0] w_thr_m;
  logic [WIDTH-1:0] w_thr_u;
  logic [WIDTH-1:0] w_oh;
  logic             w_vld_m;
  logic             w_vld_u;
  logic             w_done;

  assign w_done = (r_state == GRANT) && ack && lst;

  // Positions strictly above the current one-hot winner (zero for the top bit).
  assign w_msk_above = ~(r_gnt | (r_gnt - WIDTH'(1)));

  // While granting, re-arbitration looks ahead with the post-packet mask and
  // drops the current winner so it can only come back through IDLE.
  assign w_req_eff = (r_state == GRANT) ? (req & ~r_gnt) : req;
  assign w_msk_eff = (r_state == GRANT) ? w_msk_above : r_msk;
  assign w_req_m   = w_req_eff & w_msk_eff;

  pry2thr #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_thr_masked (
    .pry (w_req_m),
    .thr (w_thr_m),
    .vld (w_vld_m)
  );

  pry2thr #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION),
    .DIRECTION      ("LSB")
  ) u_thr_unmasked (
    .pry (w_req_eff),
    .thr (w_thr_u),
    .vld (w_vld_u)
  );

  assign w_oh = w_vld_m ? WIDTH'(onehot_from_thr(MAX_W'(w_thr_m)))
                        : WIDTH'(onehot_from_thr(MAX_W'(w_thr_u)));

  // Binary index of the selected one-hot by OR-ing in each set position.
  always_comb begin
    w_idx_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_oh[i]) begin
        w_idx_sel = w_idx_sel | C_IW'(i);
      end
    end
  end

  // Next-state: load a winner from IDLE, hold while locked, hand over on last.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_msk_nxt   = r_msk;
    case (r_state)
      IDLE: begin
        if (w_vld_u) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_oh;
          w_idx_nxt   = w_idx_sel;
        end
      end
      GRANT: begin
        if (w_done) begin
          w_msk_nxt = w_msk_above;
          if (w_vld_u) begin
            w_gnt_nxt = w_oh;
            w_idx_nxt = w_idx_sel;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops any lock immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_msk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_msk   <= w_msk_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rrb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrb_arb
// Brief    : Scoreboard bench for rrb_arb (WIDTH=8/SPLIT=2 and
//            WIDTH=5/SPLIT=3). Stimulus queues expected {vld,gnt,idx};
//            monitors pop on every change of the DUT output tuple.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrb_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic       lst;
  logic [7:0] gnt;
  logic       gnt_vld;
  logic [2:0] gnt_idx;

  logic [4:0] req5;
  logic       ack5;
  logic       lst5;
  logic [4:0] gnt5;
  logic       gnt_vld5;
  logic [2:0] gnt_idx5;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] q8[$];
  logic [8:0]  q5[$];
  logic [11:0] prev8 = '0;
  logic [11:0] cur8;
  logic [11:0] e8;
  logic [8:0]  prev5 = '0;
  logic [8:0]  cur5;
  logic [8:0]  e5;

  always #5 clk = ~clk;

  rrb_arb #(.WIDTH(8), .SPLIT(2), .IMPLEMENTATION(0)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .ack     (ack),
    .lst     (lst)
  );

  rrb_arb #(.WIDTH(5), .SPLIT(3), .IMPLEMENTATION(1)) u_dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req5),
    .gnt     (gnt5),
    .gnt_vld (gnt_vld5),
    .gnt_idx (gnt_idx5),
    .ack     (ack5),
    .lst     (lst5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp8(input logic v, input logic [7:0] g, input logic [2:0] i);
    q8.push_back({v, g, i});
  endtask

  task automatic exp5(input logic v, input logic [4:0] g, input logic [2:0] i);
    q5.push_back({v, g, i});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor for the 8-wide arbiter: every output change must match the queue.
  always @(negedge clk) begin
    cur8 = {gnt_vld, gnt, gnt_idx};
    if (cur8 !== prev8) begin
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL w8_unexpected: got vld/gnt/idx %0h, nothing expected", cur8);
      end else begin
        e8 = q8.pop_front();
        if (cur8 !== e8) begin
          n_fail++;
          $display("FAIL w8_grant: got vld/gnt/idx %0h expected %0h", cur8, e8);
        end
      end
      prev8 = cur8;
    end
  end

  // Monitor for the 5-wide arbiter.
  always @(negedge clk) begin
    cur5 = {gnt_vld5, gnt5, gnt_idx5};
    if (cur5 !== prev5) begin
      n_tests++;
      if (q5.size() == 0) begin
        n_fail++;
        $display("FAIL w5_unexpected: got vld/gnt/idx %0h, nothing expected", cur5);
      end else begin
        e5 = q5.pop_front();
        if (cur5 !== e5) begin
          n_fail++;
          $display("FAIL w5_grant: got vld/gnt/idx %0h expected %0h", cur5, e5);
        end
      end
      prev5 = cur5;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0; ack  = 1'b0; lst  = 1'b0;
    req5  = '0; ack5 = 1'b0; lst5 = 1'b0;
    repeat (3) step();
    chk("reset_gnt",     32'(gnt),     32'h0);
    chk("reset_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("reset_gnt_idx", 32'(gnt_idx), 32'h0);
    rst_n = 1'b1;
    step();

    // Basic grant then back-to-back handover, then idle.
    req = 8'b0010_0100; exp8(1'b1, 8'b0000_0100, 3'd2); step();
    ack = 1'b1; lst = 1'b1; exp8(1'b1, 8'b0010_0000, 3'd5); step();
    req = 8'h00; exp8(1'b0, 8'h00, 3'd0); step();
    ack = 1'b0; lst = 1'b0; step();

    // Wrap-around: winner 7 resets the pointer, so 0 then 7 again.
    req = 8'b1000_0000; exp8(1'b1, 8'b1000_0000, 3'd7); step();
    ack = 1'b1; lst = 1'b1; req = 8'b1000_0001;
    exp8(1'b1, 8'b0000_0001, 3'd0); step();
    exp8(1'b1, 8'b1000_0000, 3'd7); step();
    req = 8'h00; exp8(1'b0, 8'h00, 3'd0); step();
    ack = 1'b0; lst = 1'b0; step();

    // Lock: winner 1 holds through three non-last beats and a req change.
    req = 8'b0000_0011; exp8(1'b1, 8'b0000_0001, 3'd0); step();
    ack = 1'b1; lst = 1'b1; exp8(1'b1, 8'b0000_0010, 3'd1); step();
    lst = 1'b0; step();
    req = 8'b0000_1011; step();
    req = 8'b0000_0011; step();
    lst = 1'b1; exp8(1'b1, 8'b0000_0001, 3'd0); step();
    req = 8'h00; exp8(1'b0, 8'h00, 3'd0); step();

    // ack/lst while idle must not start anything.
    step(); step();
    ack = 1'b0; lst = 1'b0; step();
    chk("idle_ack_vld", 32'(gnt_vld), 32'h0);

    // Async reset in the middle of a locked packet.
    req = 8'b0001_0000; exp8(1'b1, 8'b0001_0000, 3'd4); step();
    ack = 1'b1; lst = 1'b0; step();
    #2;
    exp8(1'b0, 8'h00, 3'd0);
    rst_n = 1'b0; ack = 1'b0; req = 8'h00;
    #1;
    chk("async_rst_gnt",     32'(gnt),     32'h0);
    chk("async_rst_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("async_rst_gnt_idx", 32'(gnt_idx), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Fairness: all requesting, pointer at reset, 16 packets in index order.
    req = 8'hFF; ack = 1'b1; lst = 1'b1;
    exp8(1'b1, 8'h01, 3'd0); step();
    for (int k = 1; k < 16; k++) begin
      exp8(1'b1, 8'(1 << (k % 8)), 3'(k % 8));
      step();
    end
    req = 8'h00; exp8(1'b0, 8'h00, 3'd0); step();
    ack = 1'b0; lst = 1'b0; step();

    // Non-power-of-split width: 5 requesters, split 3.
    req5 = 5'b10001; ack5 = 1'b1; lst5 = 1'b1;
    exp5(1'b1, 5'b00001, 3'd0); step();
    exp5(1'b1, 5'b10000, 3'd4); step();
    exp5(1'b1, 5'b00001, 3'd0); step();
    req5 = 5'b00000; exp5(1'b0, 5'b00000, 3'd0); step();
    ack5 = 1'b0; lst5 = 1'b0;

    repeat (2) step();
    chk("w8_queue_drained", 32'(q8.size()), 32'h0);
    chk("w5_queue_drained", 32'(q5.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
